// File: rtl/tap_ir_dr.sv
// JTAG instruction/data register block that sits downstream of the TAP state machine.
// Latency: registers update on posedge TCK; TDO/TDO_EN update on the following negedge.
// Backpressure: none; the block follows STATE_IN every TCK cycle, and unknown states hold all registers.
module tap_ir_dr #(
  parameter int          IR_WIDTH   = 4,
  parameter int          USER_WIDTH = 8,
  parameter logic [31:0] IDCODE_VAL = 32'h1000_0001
) (
  input  logic                  i_tck,
  input  logic                  i_trst,
  input  logic [3:0]            i_state_in,
  input  logic                  i_tdi,
  output logic                  o_tdo,
  output logic                  o_tdo_en,
  output logic [IR_WIDTH-1:0]   o_ir_out,
  input  logic [USER_WIDTH-1:0] i_user_in,
  output logic [USER_WIDTH-1:0] o_user_out,
  output logic                  o_user_update
);

  // TAP controller state encodings
  localparam logic [3:0] ST_TLR    = 4'hF;
  localparam logic [3:0] ST_CAP_DR = 4'h6;
  localparam logic [3:0] ST_SH_DR  = 4'h2;
  localparam logic [3:0] ST_UPD_DR = 4'h5;
  localparam logic [3:0] ST_CAP_IR = 4'hE;
  localparam logic [3:0] ST_SH_IR  = 4'hA;
  localparam logic [3:0] ST_UPD_IR = 4'hD;

  // Instruction opcodes; anything not listed falls back to BYPASS
  localparam logic [IR_WIDTH-1:0] OP_IDCODE  = IR_WIDTH'(1);
  localparam logic [IR_WIDTH-1:0] OP_USER    = IR_WIDTH'(2);
  localparam logic [IR_WIDTH-1:0] IR_CAPTURE = IR_WIDTH'(1);

  logic [IR_WIDTH-1:0]   r_ir_sh;
  logic [IR_WIDTH-1:0]   r_ir;
  logic [31:0]           r_id_sh;
  logic [USER_WIDTH-1:0] r_user_sh;
  logic [USER_WIDTH-1:0] r_user_out;
  logic                  r_user_update;
  logic                  r_bypass;
  logic                  r_tdo;
  logic                  r_tdo_en;

  logic w_sel_idcode;
  logic w_sel_user;
  logic w_dr_lsb;

  assign w_sel_idcode = (r_ir == OP_IDCODE);
  assign w_sel_user   = (r_ir == OP_USER);

  // Serial output of whichever DR the current instruction selects (EXTEST/unknown use bypass)
  always_comb begin
    w_dr_lsb = r_bypass;
    if (w_sel_idcode)    w_dr_lsb = r_id_sh[0];
    else if (w_sel_user) w_dr_lsb = r_user_sh[0];
  end

  // Instruction register: capture, LSB-first shift, update; TLR forces IDCODE
  always_ff @(posedge i_tck or posedge i_trst) begin
    if (i_trst) begin
      r_ir_sh <= '0;
      r_ir    <= OP_IDCODE;
    end else begin
      case (i_state_in)
        ST_TLR:    r_ir    <= OP_IDCODE;
        ST_CAP_IR: r_ir_sh <= IR_CAPTURE;
        ST_SH_IR:  r_ir_sh <= {i_tdi, r_ir_sh[IR_WIDTH-1:1]};
        ST_UPD_IR: r_ir    <= r_ir_sh;
        default:   ;
      endcase
    end
  end

  // Data registers: only the selected DR captures or shifts; the others hold
  always_ff @(posedge i_tck or posedge i_trst) begin
    if (i_trst) begin
      r_id_sh   <= '0;
      r_user_sh <= '0;
      r_bypass  <= 1'b0;
    end else begin
      case (i_state_in)
        ST_CAP_DR: begin
          if (w_sel_idcode)    r_id_sh   <= IDCODE_VAL;
          else if (w_sel_user) r_user_sh <= i_user_in;
          else                 r_bypass  <= 1'b0;
        end
        ST_SH_DR: begin
          if (w_sel_idcode)    r_id_sh   <= {i_tdi, r_id_sh[31:1]};
          else if (w_sel_user) r_user_sh <= {i_tdi, r_user_sh[USER_WIDTH-1:1]};
          else                 r_bypass  <= i_tdi;
        end
        default: ;
      endcase
    end
  end

  // USER parallel output and its one-cycle update strobe
  always_ff @(posedge i_tck or posedge i_trst) begin
    if (i_trst) begin
      r_user_out    <= '0;
      r_user_update <= 1'b0;
    end else begin
      r_user_update <= 1'b0;
      if (i_state_in == ST_UPD_DR && w_sel_user) begin
        r_user_out    <= r_user_sh;
        r_user_update <= 1'b1;
      end
    end
  end

  // Pin-side output: launched on negedge so TDO is stable at the next posedge
  always_ff @(negedge i_tck or posedge i_trst) begin
    if (i_trst) begin
      r_tdo    <= 1'b0;
      r_tdo_en <= 1'b0;
    end else begin
      r_tdo_en <= (i_state_in == ST_SH_IR) || (i_state_in == ST_SH_DR);
      if (i_state_in == ST_SH_IR)      r_tdo <= r_ir_sh[0];
      else if (i_state_in == ST_SH_DR) r_tdo <= w_dr_lsb;
    end
  end

  assign o_tdo         = r_tdo;
  assign o_tdo_en      = r_tdo_en;
  assign o_ir_out      = r_ir;
  assign o_user_out    = r_user_out;
  assign o_user_update = r_user_update;

endmodule

// File: tb/tb_tap_ir_dr.sv
// Directed bench for tap_ir_dr: drives TAP state codes and checks TDO, IR and USER outputs.
// Inputs change 1 time unit after posedge; outputs are sampled 1 time unit after negedge.
// No backpressure; every wait is a fixed number of clock edges.
module tb_tap_ir_dr;

  localparam logic [3:0] ST_TLR    = 4'hF;
  localparam logic [3:0] ST_RTI    = 4'hC;
  localparam logic [3:0] ST_CAP_DR = 4'h6;
  localparam logic [3:0] ST_SH_DR  = 4'h2;
  localparam logic [3:0] ST_UPD_DR = 4'h5;
  localparam logic [3:0] ST_CAP_IR = 4'hE;
  localparam logic [3:0] ST_SH_IR  = 4'hA;
  localparam logic [3:0] ST_UPD_IR = 4'hD;

  logic       tck = 1'b0;
  logic       trst;
  logic [3:0] state_in;
  logic       tdi;
  logic       tdo;
  logic       tdo_en;
  logic [3:0] ir_out;
  logic [7:0] user_in;
  logic [7:0] user_out;
  logic       user_update;

  int total = 0;
  int bad   = 0;

  tap_ir_dr #(
    .IR_WIDTH(4),
    .USER_WIDTH(8),
    .IDCODE_VAL(32'h1000_0001)
  ) dut (
    .i_tck(tck),
    .i_trst(trst),
    .i_state_in(state_in),
    .i_tdi(tdi),
    .o_tdo(tdo),
    .o_tdo_en(tdo_en),
    .o_ir_out(ir_out),
    .i_user_in(user_in),
    .o_user_out(user_out),
    .o_user_update(user_update)
  );

  always #5 tck = ~tck;

  // One TCK cycle in state st: posedge acts on the previous state, negedge samples st
  task automatic step(input logic [3:0] st, input logic d);
    @(posedge tck);
    #1;
    state_in = st;
    tdi      = d;
    @(negedge tck);
    #1;
  endtask

  task automatic load_ir(input logic [3:0] op);
    step(ST_CAP_IR, 1'b0);
    for (int i = 0; i < 4; i++) step(ST_SH_IR, op[i]);
    step(ST_UPD_IR, 1'b0);
    step(ST_RTI, 1'b0);
  endtask

  task automatic test_reset;
    #3;
    total++; if (ir_out !== 4'h1)   begin bad++; $display("FAIL reset_ir got=%h exp=1", ir_out); end
    total++; if (tdo !== 1'b0)      begin bad++; $display("FAIL reset_tdo got=%b exp=0", tdo); end
    total++; if (tdo_en !== 1'b0)   begin bad++; $display("FAIL reset_tdo_en got=%b exp=0", tdo_en); end
    total++; if (user_out !== 8'h0) begin bad++; $display("FAIL reset_user_out got=%h exp=00", user_out); end
    total++; if (user_update !== 1'b0) begin bad++; $display("FAIL reset_user_update got=%b exp=0", user_update); end
    #4;
    trst = 1'b0;
  endtask

  task automatic test_idcode;
    logic [31:0] exp_id;
    logic [31:0] tdi_pat;
    exp_id  = 32'h1000_0001;
    tdi_pat = 32'h0000_000A;
    step(ST_CAP_DR, 1'b0);
    total++; if (tdo_en !== 1'b0) begin bad++; $display("FAIL idcode_en_cap got=%b exp=0", tdo_en); end
    for (int i = 0; i < 32; i++) begin
      step(ST_SH_DR, tdi_pat[i]);
      total++; if (tdo !== exp_id[i]) begin bad++; $display("FAIL idcode_bit%0d got=%b exp=%b", i, tdo, exp_id[i]); end
      total++; if (tdo_en !== 1'b1)   begin bad++; $display("FAIL idcode_en_sh%0d got=%b exp=1", i, tdo_en); end
    end
    // Shifting past 32 bits returns the TDI data that went in first
    for (int i = 0; i < 4; i++) begin
      step(ST_SH_DR, 1'b0);
      total++; if (tdo !== tdi_pat[i]) begin bad++; $display("FAIL idcode_recirc%0d got=%b exp=%b", i, tdo, tdi_pat[i]); end
    end
    step(ST_UPD_DR, 1'b0);
    total++; if (tdo_en !== 1'b0) begin bad++; $display("FAIL idcode_en_upd got=%b exp=0", tdo_en); end
    step(ST_RTI, 1'b0);
  endtask

  task automatic test_ir_shift;
    logic [3:0] exp_tdo;
    exp_tdo = 4'b0001;
    step(ST_CAP_IR, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step(ST_SH_IR, 1'b1);
      total++; if (tdo !== exp_tdo[i]) begin bad++; $display("FAIL ir_tdo%0d got=%b exp=%b", i, tdo, exp_tdo[i]); end
      total++; if (tdo_en !== 1'b1)    begin bad++; $display("FAIL ir_en%0d got=%b exp=1", i, tdo_en); end
    end
    step(ST_UPD_IR, 1'b0);
    total++; if (ir_out !== 4'h1) begin bad++; $display("FAIL ir_before_upd got=%h exp=1", ir_out); end
    step(ST_RTI, 1'b0);
    total++; if (ir_out !== 4'hF) begin bad++; $display("FAIL ir_after_upd got=%h exp=F", ir_out); end
  endtask

  task automatic test_bypass;
    logic [3:0] din;
    logic [3:0] exp_tdo;
    din     = 4'b1101;   // sent 1,0,1,1
    exp_tdo = 4'b1010;   // seen 0,1,0,1
    step(ST_CAP_DR, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step(ST_SH_DR, din[i]);
      total++; if (tdo !== exp_tdo[i]) begin bad++; $display("FAIL bypass_tdo%0d got=%b exp=%b", i, tdo, exp_tdo[i]); end
    end
    step(ST_RTI, 1'b0);
  endtask

  task automatic test_user;
    logic [7:0] cap;
    logic [7:0] din;
    cap = 8'hA5;
    din = 8'h3C;
    load_ir(4'h2);
    total++; if (ir_out !== 4'h2) begin bad++; $display("FAIL user_ir got=%h exp=2", ir_out); end
    user_in = cap;
    step(ST_CAP_DR, 1'b0);
    for (int i = 0; i < 8; i++) begin
      step(ST_SH_DR, din[i]);
      total++; if (tdo !== cap[i]) begin bad++; $display("FAIL user_tdo%0d got=%b exp=%b", i, tdo, cap[i]); end
    end
    step(ST_UPD_DR, 1'b0);
    total++; if (user_update !== 1'b0) begin bad++; $display("FAIL user_upd_early got=%b exp=0", user_update); end
    step(ST_RTI, 1'b0);
    total++; if (user_out !== 8'h3C)   begin bad++; $display("FAIL user_out got=%h exp=3C", user_out); end
    total++; if (user_update !== 1'b1) begin bad++; $display("FAIL user_upd_pulse got=%b exp=1", user_update); end
    step(ST_RTI, 1'b0);
    total++; if (user_update !== 1'b0) begin bad++; $display("FAIL user_upd_end got=%b exp=0", user_update); end
    total++; if (user_out !== 8'h3C)   begin bad++; $display("FAIL user_out_hold got=%h exp=3C", user_out); end
  endtask

  task automatic test_user_no_shift;
    user_in = 8'h5A;
    step(ST_CAP_DR, 1'b0);
    step(ST_UPD_DR, 1'b0);
    step(ST_RTI, 1'b0);
    total++; if (user_out !== 8'h5A)   begin bad++; $display("FAIL user_relatch got=%h exp=5A", user_out); end
    total++; if (user_update !== 1'b1) begin bad++; $display("FAIL user_relatch_pulse got=%b exp=1", user_update); end
    // TLR resets the instruction but leaves USER_OUT alone
    step(ST_TLR, 1'b0);
    step(ST_RTI, 1'b0);
    total++; if (ir_out !== 4'h1)    begin bad++; $display("FAIL user_tlr_ir got=%h exp=1", ir_out); end
    total++; if (user_out !== 8'h5A) begin bad++; $display("FAIL user_tlr_hold got=%h exp=5A", user_out); end
  endtask

  task automatic test_unknown_ir;
    logic [2:0] din;
    logic [2:0] exp_tdo;
    din     = 3'b011;   // sent 1,1,0
    exp_tdo = 3'b110;   // seen 0,1,1
    load_ir(4'h7);
    total++; if (ir_out !== 4'h7) begin bad++; $display("FAIL unk_ir got=%h exp=7", ir_out); end
    step(ST_CAP_DR, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(ST_SH_DR, din[i]);
      total++; if (tdo !== exp_tdo[i]) begin bad++; $display("FAIL unk_tdo%0d got=%b exp=%b", i, tdo, exp_tdo[i]); end
    end
    step(ST_TLR, 1'b0);
    step(ST_RTI, 1'b0);
    total++; if (ir_out !== 4'h1) begin bad++; $display("FAIL unk_tlr_ir got=%h exp=1", ir_out); end
  endtask

  task automatic test_trst_mid_shift;
    load_ir(4'hF);
    step(ST_CAP_DR, 1'b0);
    for (int i = 0; i < 10; i++) step(ST_SH_DR, 1'b1);
    total++; if (tdo !== 1'b1)    begin bad++; $display("FAIL trst_pre_tdo got=%b exp=1", tdo); end
    total++; if (tdo_en !== 1'b1) begin bad++; $display("FAIL trst_pre_en got=%b exp=1", tdo_en); end
    trst = 1'b1;
    #1;
    total++; if (tdo !== 1'b0)      begin bad++; $display("FAIL trst_tdo got=%b exp=0", tdo); end
    total++; if (tdo_en !== 1'b0)   begin bad++; $display("FAIL trst_en got=%b exp=0", tdo_en); end
    total++; if (ir_out !== 4'h1)   begin bad++; $display("FAIL trst_ir got=%h exp=1", ir_out); end
    total++; if (user_out !== 8'h0) begin bad++; $display("FAIL trst_user_out got=%h exp=00", user_out); end
    state_in = ST_RTI;
    #1;
    trst = 1'b0;
    step(ST_RTI, 1'b0);
    total++; if (ir_out !== 4'h1) begin bad++; $display("FAIL trst_after_ir got=%h exp=1", ir_out); end
  endtask

  initial begin
    trst     = 1'b1;
    state_in = ST_RTI;
    tdi      = 1'b0;
    user_in  = 8'h00;
    test_reset();
    test_idcode();
    test_ir_shift();
    test_bypass();
    test_user();
    test_user_no_shift();
    test_unknown_ir();
    test_trst_mid_shift();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
